// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - request/ready link between muldiv_ctrl and the shared unsigned mul/div units
//
// Ports (signals):
//   mul_req_o, div_req_o   controller -> unit  level request, held until matching ready
//   a_o, b_o               controller -> unit  unsigned operands, stable while requesting
//   mul_ready_i            unit -> controller  one-cycle product valid
//   mul_result_i           unit -> controller  2*XLEN unsigned product
//   div_ready_i            unit -> controller  one-cycle quotient/remainder valid
//   div_result_i           unit -> controller  {remainder, quotient}, each XLEN wide
// Modports: master (controller side), slave (unit side).

interface muldiv_ctrl_if #(
  parameter int XLEN = 32
);

  logic                mul_req_o;
  logic                div_req_o;
  logic [XLEN-1:0]     a_o;
  logic [XLEN-1:0]     b_o;
  logic                mul_ready_i;
  logic [2*XLEN-1:0]   mul_result_i;
  logic                div_ready_i;
  logic [2*XLEN-1:0]   div_result_i;

  modport master (
    output mul_req_o, div_req_o, a_o, b_o,
    input  mul_ready_i, mul_result_i, div_ready_i, div_result_i
  );

  modport slave (
    input  mul_req_o, div_req_o, a_o, b_o,
    output mul_ready_i, mul_result_i, div_ready_i, div_result_i
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - RV32M sequencer between execute stage and shared multi-cycle mul/div units
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             M-type op valid from execute
//   funct3_i            0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   op1_i, op2_i        rs1 / rs2 values
//   flush_i             abort the current op
//   stall_o             hold the pipeline
//   done_o              one-cycle pulse, result_o valid
//   result_o            rd write data, held until the next done
//   unit_if (master)    request/ready link to the unsigned mul/div units

module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  muldiv_ctrl_if.master   unit_if
);

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    MUL_BUSY,
    DIV_BUSY,
    DONE,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand pre-conditioning, evaluated on the incoming op
  logic              abs_a, abs_b;
  logic [XLEN-1:0]   a_cond, b_cond;
  logic              div_by_zero, div_overflow;

  // Result sign correction, evaluated on the captured unit output
  logic              mul_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   div_res;

  logic              stall_c, done_c, mul_req_c, div_req_c;

  always_comb begin
    abs_a = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
            (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    abs_b = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    a_cond = (abs_a && op1_i[XLEN-1]) ? -op1_i : op1_i;
    b_cond = (abs_b && op2_i[XLEN-1]) ? -op2_i : op2_i;
    div_by_zero  = funct3_i[2] && (op2_i == '0);
    // Only DIV and REM are signed divides (funct3 bit 0 clear)
    div_overflow = funct3_i[2] && !funct3_i[0] &&
                   (op1_i == INT_MIN) && (op2_i == '1);
  end

  always_comb begin
    mul_neg = 1'b0;
    if (funct3_q == F3_MULH)   mul_neg = neg_a_q ^ neg_b_q;
    if (funct3_q == F3_MULHSU) mul_neg = neg_a_q;
    // Negating the full 2*XLEN product keeps the high half correct for signed results
    prod_fix = mul_neg ? -unit_if.mul_result_i : unit_if.mul_result_i;
    mul_res  = (funct3_q == F3_MUL) ? unit_if.mul_result_i[XLEN-1:0]
                                    : prod_fix[2*XLEN-1:XLEN];

    quot = unit_if.div_result_i[XLEN-1:0];
    rem  = unit_if.div_result_i[2*XLEN-1:XLEN];
    case (funct3_q)
      F3_DIV:  div_res = (neg_a_q ^ neg_b_q) ? -quot : quot;
      F3_DIVU: div_res = quot;
      F3_REM:  div_res = neg_a_q ? -rem : rem;
      default: div_res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    stall_c   = 1'b0;
    done_c    = 1'b0;
    mul_req_c = 1'b0;
    div_req_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          stall_c  = 1'b1;
          funct3_d = funct3_i;
          neg_a_d  = op1_i[XLEN-1];
          neg_b_d  = op2_i[XLEN-1];
          a_d      = a_cond;
          b_d      = b_cond;
          if (div_by_zero) begin
            result_d = funct3_i[1] ? op1_i : '1;
            state_d  = DONE;
          end else if (div_overflow) begin
            result_d = funct3_i[1] ? '0 : INT_MIN;
            state_d  = DONE;
          end else begin
            state_d  = funct3_i[2] ? DIV_BUSY : MUL_BUSY;
          end
        end
      end

      MUL_BUSY: begin
        stall_c   = 1'b1;
        mul_req_c = 1'b1;
        // A ready arriving with the flush already completes the unit, so no drain is needed
        if (unit_if.mul_ready_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            result_d = mul_res;
            state_d  = DONE;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end

      DIV_BUSY: begin
        stall_c   = 1'b1;
        div_req_c = 1'b1;
        if (unit_if.div_ready_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            result_d = div_res;
            state_d  = DONE;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end

      DONE: begin
        done_c  = !flush_i;
        state_d = IDLE;
      end

      DRAIN: begin
        // Keep the request up so the unit finishes cleanly; its result is dropped
        stall_c = 1'b1;
        if (funct3_q[2]) begin
          div_req_c = 1'b1;
          if (unit_if.div_ready_i) state_d = IDLE;
        end else begin
          mul_req_c = 1'b1;
          if (unit_if.mul_ready_i) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign stall_o           = stall_c;
  assign done_o            = done_c;
  assign result_o          = result_q;
  assign unit_if.mul_req_o = mul_req_c;
  assign unit_if.div_req_o = div_req_c;
  assign unit_if.a_o       = a_q;
  assign unit_if.b_o       = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl with behavioural unit and result model

module tb_muldiv_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [2:0]      f3;
  logic [XLEN-1:0] op1, op2;
  logic            stall, done;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  int unit_lat = 3;
  bit spur_mul = 1'b0;
  bit active;
  int cnt;

  logic [XLEN-1:0] last_res = '0;

  muldiv_ctrl_if #(.XLEN(XLEN)) u ();

  muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .funct3_i (f3),
    .op1_i    (op1),
    .op2_i    (op2),
    .flush_i  (flush),
    .stall_o  (stall),
    .done_o   (done),
    .result_o (result),
    .unit_if  (u.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Unsigned mul/div units: answer a held request after unit_lat cycles
  initial begin
    u.mul_ready_i  = 1'b0;
    u.div_ready_i  = 1'b0;
    u.mul_result_i = '0;
    u.div_result_i = '0;
    active = 1'b0;
    cnt    = 0;
    forever begin
      @(negedge clk);
      u.mul_ready_i = 1'b0;
      u.div_ready_i = 1'b0;
      if (!(u.mul_req_o || u.div_req_o)) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt    = unit_lat;
        end
        if (spur_mul && u.div_req_o) begin
          u.mul_ready_i  = 1'b1;
          u.mul_result_i = 64'h1234_5678_9abc_def0;
        end
        cnt--;
        if (cnt <= 0) begin
          active = 1'b0;
          if (u.mul_req_o) begin
            u.mul_ready_i  = 1'b1;
            u.mul_result_i = {32'b0, u.a_o} * {32'b0, u.b_o};
          end else begin
            u.div_ready_i  = 1'b1;
            u.div_result_i = (u.b_o == '0) ? '1 : {u.a_o % u.b_o, u.a_o / u.b_o};
          end
        end
      end
    end
  end

  function automatic logic [31:0] ref_result(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (fn)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin if (y == 0) return 32'hFFFF_FFFF; p = sx / sy; return p[31:0]; end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [31:0] ref_abs(input logic [31:0] v, input bit sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y, input int lat);
    logic [31:0] er, ea, eb;
    bit          spec;
    int          n;
    er   = ref_result(fn, x, y);
    ea   = ref_abs(x, fn == 3'd1 || fn == 3'd2 || fn == 3'd4 || fn == 3'd6);
    eb   = ref_abs(y, fn == 3'd1 || fn == 3'd4 || fn == 3'd6);
    spec = fn[2] && ((y == 0) || (!fn[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    unit_lat = lat;
    @(negedge clk);
    start = 1'b1; f3 = fn; op1 = x; op2 = y;
    #1;
    check_eq("stall_at_T", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    if (spec) begin
      check_eq("special_done", 64'(done), 64'd1);
      check_eq("special_result", 64'(result), 64'(er));
      check_eq("special_noreq", 64'({u.mul_req_o, u.div_req_o}), 64'd0);
      check_eq("special_stall", 64'(stall), 64'd0);
    end else begin
      check_eq("a_o", 64'(u.a_o), 64'(ea));
      check_eq("b_o", 64'(u.b_o), 64'(eb));
      check_eq("req", 64'({u.mul_req_o, u.div_req_o}), fn[2] ? 64'd1 : 64'd2);
      n = 0;
      while (!done && n < 100) begin
        check_eq("busy_stall", 64'(stall), 64'd1);
        @(negedge clk);
        n++;
      end
      check_eq("done", 64'(done), 64'd1);
      check_eq("latency", 64'(n), 64'(lat));
      check_eq("result", 64'(result), 64'(er));
      check_eq("done_stall", 64'(stall), 64'd0);
    end
    last_res = er;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq(tag, {stall, done, u.mul_req_o, u.div_req_o, result, u.a_o, u.b_o}, 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs_hi", {stall, done, u.mul_req_o, u.div_req_o, result}, 64'd0);
    check_eq("rst_ab", {u.a_o, u.b_o}, 64'd0);
    rst = 1'b0;

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 4);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 2);
    run_op(3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 3);
    run_op(3'd4, 32'h0000_0005, 32'h0, 3);
    run_op(3'd7, 32'h0000_0005, 32'h0, 3);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 3);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 3);

    // Stray multiplier ready while the divider is busy
    spur_mul = 1'b1;
    run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 4);
    spur_mul = 1'b0;

    // Flush during DIV_BUSY, then a start offered during DRAIN
    unit_lat = 6;
    @(negedge clk);
    start = 1'b1; f3 = 3'd4; op1 = 32'hFFFF_FFF9; op2 = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("drain_stall", 64'(stall), 64'd1);
    check_eq("drain_divreq", 64'(u.div_req_o), 64'd1);
    start = 1'b1; f3 = 3'd0; op1 = 32'd9; op2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check_eq("drain_ignore_start", 64'({stall, u.mul_req_o}), 64'd2);
    n = 0;
    while (stall && n < 50) begin
      check_eq("drain_no_done", 64'(done), 64'd0);
      @(negedge clk);
      n++;
    end
    check_eq("drain_exit_idle", 64'({stall, done, u.mul_req_o, u.div_req_o}), 64'd0);
    check_eq("drain_result_kept", 64'(result), 64'(last_res));
    run_op(3'd5, 32'd100, 32'd7, 2);

    // Reset while the multiplier is busy
    unit_lat = 10;
    @(negedge clk);
    start = 1'b1; f3 = 3'd0; op1 = 32'd7; op2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_zero("rst_midop");
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, 3);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), rand_op(), rand_op(), $urandom_range(1, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer between the execute stage and the shared multi-cycle multiplier and divider for RV32M.
- Accepts one M-extension op at a time (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Registers operands and applies sign pre-conditioning (absolute values).
- Drives the unsigned mul/div units over a req/ready handshake, then sign-corrects and selects the result.
- Raises pipeline stall while busy, short-circuits divide-by-zero and signed overflow, and supports flush with safe drain.

Parameters:
XLEN, 32, operand/result width; unit results are 2*XLEN.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  M-type op valid from execute stage
funct3_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1_i  in  XLEN  rs1 value
op2_i  in  XLEN  rs2 value
flush_i  in  1  abort current op (branch/trap)
stall_o  out  1  hold pipeline
done_o  out  1  one-cycle pulse, result_o valid
result_o  out  XLEN  rd write data
mul_req_o  out  1  multiplier request, level, held until mul_ready_i
div_req_o  out  1  divider request, level, held until div_ready_i
a_o  out  XLEN  unsigned operand A to unit
b_o  out  XLEN  unsigned operand B to unit
mul_ready_i  in  1  multiplier result valid (one cycle)
mul_result_i  in  2*XLEN  unsigned product
div_ready_i  in  1  divider result valid (one cycle)
div_result_i  in  2*XLEN  [XLEN-1:0] unsigned quotient, [2*XLEN-1:XLEN] unsigned remainder

Behaviour:
- Reset: state IDLE. All outputs 0: stall_o, done_o, result_o, mul_req_o, div_req_o, a_o, b_o. Internal result/sign registers cleared. Reset mid-operation drops req immediately; units are reset by the same rst_i.
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE, DRAIN.
- IDLE, start_i=1, flush_i=0 (cycle T):
  - Latch funct3, neg_a = op1 sign, neg_b = op2 sign.
  - a_o/b_o get operands, abs() applied where signed: MULH both; MULHSU op1 only; DIV/REM both; MUL, MULHU, DIVU, REMU raw.
  - Special case op2==0 with funct3>=4: no request; result = all-ones for DIV/DIVU, op1 for REM/REMU; go to DONE.
  - Special case DIV/REM with op1=0x80000000, op2=0xFFFFFFFF: no request; result 0x80000000 (DIV) or 0 (REM); go to DONE.
  - Otherwise go to MUL_BUSY or DIV_BUSY.
- MUL_BUSY/DIV_BUSY: respective req_o=1, a_o/b_o stable. On ready_i, capture the 2*XLEN result; go to DONE.
- Sign fix, applied on capture:
  - MUL: product[XLEN-1:0].
  - MULH: high half of the 2*XLEN two's-complement negation when neg_a^neg_b.
  - MULHSU: same negation when neg_a.
  - MULHU: high half raw.
  - DIV: negate quotient if neg_a^neg_b.
  - REM: negate remainder if neg_a.
  - DIVU/REMU: raw.
- DONE: done_o=1 for exactly one cycle, result_o valid; next state IDLE. result_o holds its value until the next DONE.
- Latency:
  - Normal op: done_o at cycle R+1, where R is the ready cycle. req_o first asserted at T+1.
  - Special-case divide: done_o at T+1.
  - No back-to-back start in DONE; a new start is accepted next IDLE cycle.
- stall_o = (IDLE & start_i & ~flush_i) | MUL_BUSY | DIV_BUSY | DRAIN. It is 0 in DONE, which releases the pipeline in the same cycle rd is written.
- Flush:
  - In IDLE or DONE, flush_i suppresses start/done; no done_o pulse.
  - In BUSY, go to DRAIN with req held until ready_i; discard result, no done_o; return to IDLE.
  - In DRAIN, stall_o=1 and start_i is ignored.
- ready_i seen when that unit's req_o=0: ignored.
- Invalid funct3 cannot occur (3 bits cover all 8 ops).

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), unit ready after 4 cycles -> a_o=7, b_o=0xFFFFFFFD raw; done_o one cycle after ready; result 0xFFFFFFEB; stall_o high T..R, low in DONE.
- MULH 0x80000000 x 0x80000000 -> a_o=b_o=0x80000000; result 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV -7/2 -> a_o=7, b_o=2; result 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIV 5/0 -> no div_req_o; done_o at T+1; result 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same -> 0.
- flush_i during DIV_BUSY -> div_req_o held until div_ready_i; no done_o; stall_o high through DRAIN; start_i during DRAIN ignored; next start in IDLE completes normally.
- rst_i asserted in MUL_BUSY -> next cycle all outputs 0, state IDLE; subsequent MUL 3x4 -> result 12.
